// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for an async FIFO: 2-entry skid buffer, read-pointer synchronizer,
// and optional occupancy/almost-full reporting compiled in with FIFO_WR_LEVEL_EN.
module fifo_wr_ctrl #(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned ASIZE     = 4,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic             wclk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic             in_ready,
  input  logic             wfull,
  input  logic [ASIZE:0]   wptr,
  input  logic [ASIZE:0]   rptr,
  output logic [ASIZE:0]   wq2_rptr,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  output logic [ASIZE:0]   wlevel,
  output logic             walmost_full
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    BLOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic [1:0]       count_pop;
  logic [DSIZE-1:0] buf0_q, buf0_d;
  logic [DSIZE-1:0] buf1_q, buf1_d;
  logic             push;
  logic             pop;
  logic [ASIZE:0]   rq1_q, rq2_q;

  // Handshake decoded from registers only; winc must drop the same cycle wfull rises.
  assign in_ready = (count_q != 2'd2);
  assign winc     = (state_q != IDLE) && !wfull;
  assign wdata    = buf0_q;
  assign push     = in_valid && in_ready;
  assign pop      = winc;
  assign wq2_rptr = rq2_q;

  // buf0 is always the oldest word; a push lands in the first free slot after the pop.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    count_pop = count_q - 2'(pop);
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (push) begin
      if (count_pop == 2'd0) begin
        buf0_d = in_data;
      end else begin
        buf1_d = in_data;
      end
    end
    count_d = count_pop + 2'(push);
    if (count_d == 2'd0) begin
      state_d = IDLE;
    end else if (wfull) begin
      state_d = BLOCKED;
    end else begin
      state_d = XFER;
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= 2'd0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  // Plain two-flop synchronizer for the read pointer.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= rptr;
      rq2_q <= rq1_q;
    end
  end

`ifdef FIFO_WR_LEVEL_EN
  localparam int unsigned PW       = ASIZE + 1;
  localparam int unsigned DEPTH    = 1 << ASIZE;
  localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

  logic [ASIZE:0] wlevel_q, wlevel_d;
  logic           walmost_full_q, walmost_full_d;

  // Gray to binary: bit i is the XOR of all Gray bits at or above i.
  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  always_comb begin
    wlevel_d       = gray2bin(wptr) - gray2bin(rq2_q);
    walmost_full_d = (wlevel_d >= PW'(AF_LEVEL));
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wlevel_q       <= '0;
      walmost_full_q <= 1'b0;
    end else begin
      wlevel_q       <= wlevel_d;
      walmost_full_q <= walmost_full_d;
    end
  end

  assign wlevel       = wlevel_q;
  assign walmost_full = walmost_full_q;
`else
  logic unused_wptr;

  assign unused_wptr  = ^wptr;
  assign wlevel       = '0;
  assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: queue-based reference model checked every cycle, plus directed scenarios.
module tb_fifo_wr_ctrl;

  logic       wclk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wfull;
  logic [4:0] wptr;
  logic [4:0] rptr;
  logic [4:0] wq2_rptr;
  logic       winc;
  logic [7:0] wdata;
  logic [4:0] wlevel;
  logic       walmost_full;

`ifdef FIFO_WR_LEVEL_EN
  localparam bit LVL_ON = 1'b1;
`else
  localparam bit LVL_ON = 1'b0;
`endif
  localparam int AF_THRESH = 16 - 2;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  int         wr_log[$];
  int         sq1, sq2, lvl_exp, af_exp;

  fifo_wr_ctrl #(.DSIZE(8), .ASIZE(4), .AF_MARGIN(2)) dut (
    .wclk         (wclk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .wfull        (wfull),
    .wptr         (wptr),
    .rptr         (rptr),
    .wq2_rptr     (wq2_rptr),
    .winc         (winc),
    .wdata        (wdata),
    .wlevel       (wlevel),
    .walmost_full (walmost_full)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Top-down decode: each binary bit is the one above it XOR the Gray bit.
  function automatic int ungray(input int g);
    int b;
    b = 0;
    for (int i = 4; i >= 0; i--) begin
      b = b | ((((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i);
    end
    return b;
  endfunction

  // Reference model: checks outputs mid-cycle, then advances to the state after the next edge.
  always @(negedge wclk) begin
    int e_ready;
    int e_winc;
    if (!rst_n) begin
      mq.delete();
      sq1 = 0;
      sq2 = 0;
      lvl_exp = 0;
      af_exp = 0;
    end
    e_ready = (mq.size() < 2) ? 1 : 0;
    e_winc  = (mq.size() > 0 && !wfull) ? 1 : 0;
    chk("m_ready", int'(in_ready), e_ready);
    chk("m_winc", int'(winc), e_winc);
    if (e_winc == 1) chk("m_wdata", int'(wdata), int'(mq[0]));
    if (!rst_n) chk("m_wdata_rst", int'(wdata), 0);
    chk("m_wq2", int'(wq2_rptr), sq2);
    chk("m_wlevel", int'(wlevel), LVL_ON ? lvl_exp : 0);
    chk("m_af", int'(walmost_full), LVL_ON ? af_exp : 0);
    if (winc) wr_log.push_back(int'(wdata));
    if (rst_n) begin
      lvl_exp = (ungray(int'(wptr)) - ungray(sq2)) & 31;
      af_exp  = (lvl_exp >= AF_THRESH) ? 1 : 0;
      sq2 = sq1;
      sq1 = int'(rptr);
      if (e_winc == 1) void'(mq.pop_front());
      if (in_valid && e_ready == 1) mq.push_back(in_data);
    end
  end

  initial begin
    int acc;
    int not_ready;
    int errs;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    wfull    = 1'b0;
    wptr     = 5'd0;
    rptr     = 5'd0;
    repeat (3) @(posedge wclk);
    #3;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_winc", int'(winc), 0);
    chk("rst_wdata", int'(wdata), 0);
    chk("rst_wq2", int'(wq2_rptr), 0);
    chk("rst_wlevel", int'(wlevel), 0);
    chk("rst_af", int'(walmost_full), 0);
    @(posedge wclk); #1 rst_n = 1'b1;

    // Single word
    @(posedge wclk); #1 in_valid = 1'b1; in_data = 8'hA5;
    @(posedge wclk); #1 in_valid = 1'b0; in_data = 8'h00;
    #2;
    chk("single_winc", int'(winc), 1);
    chk("single_wdata", int'(wdata), 8'hA5);
    @(posedge wclk); #3;
    chk("single_winc_after", int'(winc), 0);
    chk("single_ready_after", int'(in_ready), 1);

    // Stall under wfull
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wclk); #1 in_valid = 1'b1; in_data = 8'(8'h40 + i); wfull = 1'b1;
      #2;
      if (in_ready) acc++;
    end
    @(posedge wclk); #1 in_valid = 1'b0;
    #2;
    chk("stall_accepted", acc, 2);
    chk("stall_ready", int'(in_ready), 0);
    chk("stall_winc", int'(winc), 0);
    @(posedge wclk); #1 wfull = 1'b0;
    #2;
    chk("drain0_winc", int'(winc), 1);
    chk("drain0_wdata", int'(wdata), 8'h40);
    @(posedge wclk); #3;
    chk("drain1_winc", int'(winc), 1);
    chk("drain1_wdata", int'(wdata), 8'h41);
    @(posedge wclk); #3;
    chk("drain_done", int'(winc), 0);

    // Streaming 32 words
    wr_log.delete();
    not_ready = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge wclk); #1 in_valid = 1'b1; in_data = 8'(i);
      #2;
      if (!in_ready) not_ready++;
    end
    @(posedge wclk); #1 in_valid = 1'b0;
    repeat (3) @(posedge wclk);
    #3;
    chk("stream_ready_drops", not_ready, 0);
    chk("stream_count", wr_log.size(), 32);
    errs = 0;
    for (int i = 0; i < wr_log.size(); i++) begin
      if (wr_log[i] != i) errs++;
    end
    chk("stream_order_errs", errs, 0);

    // Level and wrap-around
    @(posedge wclk); #1 wptr = 5'(gray(14)); rptr = 5'(gray(0));
    repeat (4) @(posedge wclk);
    #3;
    chk("lvl14", int'(wlevel), LVL_ON ? 14 : 0);
    chk("lvl14_af", int'(walmost_full), LVL_ON ? 1 : 0);
    @(posedge wclk); #1 wptr = 5'(gray(3)); rptr = 5'(gray(29));
    repeat (4) @(posedge wclk);
    #3;
    chk("lvl_wrap_wq2", int'(wq2_rptr), gray(29));
    chk("lvl_wrap", int'(wlevel), LVL_ON ? 6 : 0);
    chk("lvl_wrap_af", int'(walmost_full), 0);

    // Reset with two buffered words
    for (int i = 0; i < 2; i++) begin
      @(posedge wclk); #1 in_valid = 1'b1; in_data = 8'(8'h77 + i); wfull = 1'b1;
    end
    @(posedge wclk); #1 in_valid = 1'b0;
    #2;
    chk("pre_rst_ready", int'(in_ready), 0);
    @(posedge wclk); #1 rst_n = 1'b0; wfull = 1'b0;
    #2;
    chk("mid_rst_winc", int'(winc), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    wr_log.delete();
    @(posedge wclk); #1 rst_n = 1'b1;
    repeat (4) @(posedge wclk);
    #3;
    chk("post_rst_writes", wr_log.size(), 0);

    @(posedge wclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
